data_memory_arbiter: RTL and testbench

- Shares the single DataMemory port (Rd, Wr, address, In_Data, Out_Data) between two requesters.
- Requester 0 is the CPU load/store path; requester 1 is the debug/loader path.
- Runs one transaction at a time through a small FSM: latches the winner's request, drives the memory strobes for exactly one cycle, captures read data after a fixed latency and returns a one-cycle acknowledge.

---
 rtl/data_memory_arbiter.sv | 112 +++++++++++
 tb/tb_data_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of the single DataMemory port; one transaction in flight at a time.
// Define DATA_MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise r0 has fixed priority.
module data_memory_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_grant;
  logic              r_we;
  logic [2:0]        r_cnt;
  logic              r_mem_rd, r_mem_wr, r_r0_ack, r_r1_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_r0_rdata, r_r1_rdata;
  logic              w_win, w_win_we, w_latch, w_cap, w_done;

`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
  assign w_win = (r0_req && r1_req) ? ~r_last_grant : r1_req;
`else
  assign w_win = ~r0_req;
`endif
  assign w_win_we = w_win ? r1_we : r0_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE:  if (r0_req || r1_req) begin
                 w_latch     = 1'b1;
                 w_state_nxt = S_ISSUE;
               end
      S_ISSUE: w_state_nxt = r_we ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) begin
                 w_cap       = 1'b1;
                 w_state_nxt = S_DONE;
               end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_done = (w_state_nxt == S_DONE);

  // last_grant doubles as the id of the transaction in flight: it is written on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_cnt        <= 3'd0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_r0_ack     <= 1'b0;
      r_r1_ack     <= 1'b0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
    end else begin
      r_mem_rd <= w_latch & ~w_win_we;
      r_mem_wr <= w_latch &  w_win_we;
      r_r0_ack <= w_done  & ~r_last_grant;
      r_r1_ack <= w_done  &  r_last_grant;
      if (w_latch) begin
        r_last_grant <= w_win;
        r_we         <= w_win_we;
        r_mem_addr   <= w_win ? r1_addr  : r0_addr;
        r_mem_wdata  <= w_win ? r1_wdata : r0_wdata;
      end
      if (r_state == S_ISSUE)     r_cnt <= 3'(RD_LAT);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_cap && !r_last_grant) r_r0_rdata <= mem_rdata;
      if (w_cap &&  r_last_grant) r_r1_rdata <= mem_rdata;
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign r0_ack    = r_r0_ack;
  assign r1_ack    = r_r1_ack;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: memory model with RD_LAT delay line, reference memory, directed and random transactions.
`timescale 1ns/1ps
module tb_data_memory_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic r0_req, r0_we, r0_ack, r1_req, r1_we, r1_ack;
  logic [ADDR_W-1:0] r0_addr, r1_addr, mem_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata, r1_wdata, r1_rdata, mem_wdata, mem_rdata;
  logic mem_rd, mem_wr;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] dly     [RD_LAT];
  logic [DATA_W-1:0] exp_rd  [2];
  int ack_log [$];
  int rd_cnt = 0, wr_cnt = 0;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;

  // DataMemory stand-in: data valid RD_LAT cycles after Rd is seen, garbage otherwise.
  assign mem_rdata = dly[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    dly[0] <= mem_rd ? mem[mem_addr] : DATA_W'($urandom);
    for (int k = 1; k < RD_LAT; k++) dly[k] <= dly[k-1];
  end

  always @(negedge clk) begin
    if (!rst && (mem_rd || mem_wr)) begin
      checks++;
      if (mem_rd && mem_wr) begin errors++; $display("FAIL strobe_excl: rd=%b wr=%b, required never both", mem_rd, mem_wr); end
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      st_addr  = mem_addr;
      st_wdata = mem_wdata;
    end
    if (r0_ack) ack_log.push_back(0);
    if (r1_ack) ack_log.push_back(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic ack_of(input int p);
    return (p == 0) ? r0_ack : r1_ack;
  endfunction

  task automatic drive(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin r0_we = we; r0_addr = a; r0_wdata = d; r0_req = 1'b1; end
    else        begin r1_we = we; r1_addr = a; r1_wdata = d; r1_req = 1'b1; end
  endtask

  task automatic drop(input int p);
    if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int p, output int cyc);
    cyc = 0;
    while (!ack_of(p) && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!ack_of(p)) begin errors++; $display("FAIL ack_timeout: port %0d no ack after %0d cycles, required ack", p, cyc); end
  endtask

  // One uncontended transaction; returns latency and strobe counts, updates the reference model.
  task automatic txn(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     output int cyc, output int nrd, output int nwr);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    drive(p, we, a, d);
    wait_ack(p, cyc);
    drop(p);
    if (we) ref_mem[a] = d; else exp_rd[p] = ref_mem[a];
    nrd = rd_cnt - rd0; nwr = wr_cnt - wr0;
    @(negedge clk);
  endtask

  // Both ports request n writes each, holding req across consecutive transactions.
  task automatic run_both(input int n, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    int left [2];
    int k [2];
    logic [ADDR_W-1:0] ab [2];
    logic [DATA_W-1:0] db [2];
    left[0] = n; left[1] = n; k[0] = 0; k[1] = 0;
    ab[0] = a0; ab[1] = a1; db[0] = d0; db[1] = d1;
    ack_log.delete();
    drive(0, 1'b1, a0, d0); drive(1, 1'b1, a1, d1);
    for (int c = 0; c < 400 && (left[0] > 0 || left[1] > 0); c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (left[p] > 0 && ack_of(p)) begin
          ref_mem[ab[p] + ADDR_W'(k[p])] = db[p] + DATA_W'(k[p]);
          k[p]++; left[p]--;
          if (left[p] > 0) drive(p, 1'b1, ab[p] + ADDR_W'(k[p]), db[p] + DATA_W'(k[p]));
          else drop(p);
        end
      end
    end
    checks++;
    if (left[0] != 0 || left[1] != 0) begin errors++; $display("FAIL both_timeout: left r0=%0d r1=%0d, required 0", left[0], left[1]); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, r0_ack, r1_ack, r0_rdata, r1_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: rd=%b wr=%b addr=%0h wd=%0h ack=%b%b rd0=%0h rd1=%0h, required all 0",
                         mem_rd, mem_wr, mem_addr, mem_wdata, r0_ack, r1_ack, r0_rdata, r1_rdata);
    end
    drive(0, 1'b0, ADDR_W'(5), '0);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_hold: rd=%b wr=%b, required 0 0", mem_rd, mem_wr); end
    do_reset();
  endtask

  task automatic test_write_read();
    int cyc, nrd, nwr;
    txn(0, 1'b1, ADDR_W'(53), DATA_W'(123), cyc, nrd, nwr);
    checks++; if (cyc != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", cyc); end
    checks++; if (nwr != 1 || nrd != 0) begin errors++; $display("FAIL wr_strobes: wr=%0d rd=%0d want 1 0", nwr, nrd); end
    checks++; if (st_addr !== ADDR_W'(53)) begin errors++; $display("FAIL wr_addr: got %0d want 53", st_addr); end
    checks++; if (st_wdata !== DATA_W'(123)) begin errors++; $display("FAIL wr_data: got %0d want 123", st_wdata); end
    txn(1, 1'b0, ADDR_W'(53), '0, cyc, nrd, nwr);
    checks++; if (cyc != 2 + RD_LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", cyc, 2 + RD_LAT); end
    checks++; if (nrd != 1 || nwr != 0) begin errors++; $display("FAIL rd_strobes: rd=%0d wr=%0d want 1 0", nrd, nwr); end
    checks++; if (st_addr !== ADDR_W'(53)) begin errors++; $display("FAIL rd_addr: got %0d want 53", st_addr); end
    checks++; if (r1_rdata !== DATA_W'(123)) begin errors++; $display("FAIL rd_data: got %0d want 123", r1_rdata); end
    checks++; if (r0_rdata !== '0) begin errors++; $display("FAIL rd_other: r0_rdata=%0h want 0", r0_rdata); end
    txn(1, 1'b1, ADDR_W'(0), 16'hBEEF, cyc, nrd, nwr);
    checks++; if (r1_rdata !== DATA_W'(123)) begin errors++; $display("FAIL wr_keeps_rdata: got %0d want 123", r1_rdata); end
    txn(0, 1'b0, ADDR_W'(0), '0, cyc, nrd, nwr);
    checks++; if (cyc != 2 + RD_LAT) begin errors++; $display("FAIL rd0_latency: got %0d want %0d", cyc, 2 + RD_LAT); end
    checks++; if (r0_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd0_data: got %0h want beef", r0_rdata); end
  endtask

  task automatic test_contention();
    int cyc, nrd, nwr;
    do_reset();
    run_both(1, ADDR_W'(10), ADDR_W'(10), 16'hAAAA, 16'h5555);
    checks++;
    if (ack_log.size() != 2) begin errors++; $display("FAIL cont_count: got %0d acks want 2", ack_log.size()); end
    else begin
      checks++;
      if (ack_log[0] != 0 || ack_log[1] != 1) begin errors++; $display("FAIL cont_order: got %0d,%0d want 0,1", ack_log[0], ack_log[1]); end
    end
    txn(0, 1'b0, ADDR_W'(10), '0, cyc, nrd, nwr);
    checks++; if (r0_rdata !== 16'h5555) begin errors++; $display("FAIL cont_final: got %0h want 5555", r0_rdata); end
  endtask

  task automatic test_back_to_back();
    int exp_q [$];
    int cyc, nrd, nwr;
    do_reset();
    run_both(4, ADDR_W'(100), ADDR_W'(200), DATA_W'($urandom), DATA_W'($urandom));
    for (int i = 0; i < 8; i++) begin
`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
      exp_q.push_back(i % 2);
`else
      exp_q.push_back(i / 4);
`endif
    end
    checks++;
    if (ack_log.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d acks want 8", ack_log.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ack_log[i] != exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d]: got r%0d want r%0d", i, ack_log[i], exp_q[i]); end
      end
    end
    txn(0, 1'b0, ADDR_W'(203), '0, cyc, nrd, nwr);
    checks++; if (r0_rdata !== ref_mem[203]) begin errors++; $display("FAIL b2b_data: got %0h want %0h", r0_rdata, ref_mem[203]); end
  endtask

  task automatic test_abort();
    int cyc, nrd, nwr;
    logic seen;
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom) | 16'h0001;
    txn(1, 1'b1, ADDR_W'(2047), v, cyc, nrd, nwr);
    for (int ab = 1; ab <= 2; ab++) begin
      txn(0, 1'b0, ADDR_W'(53), '0, cyc, nrd, nwr);
      drive(0, 1'b0, ADDR_W'(2047), '0);
      repeat (ab) @(negedge clk);
      if (ab == 1) begin
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL abort_pre: mem_rd=%b want 1 in issue", mem_rd); end
      end
      rst = 1'b1;
      #1;
      checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL abort_strobe[%0d]: rd=%b wr=%b want 0", ab, mem_rd, mem_wr); end
      checks++; if (r0_ack !== 1'b0) begin errors++; $display("FAIL abort_ack[%0d]: got %b want 0", ab, r0_ack); end
      checks++; if (r0_rdata !== '0) begin errors++; $display("FAIL abort_rdata[%0d]: got %0h want 0", ab, r0_rdata); end
      drop(0);
      @(negedge clk); rst = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (r0_ack || r1_ack) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_noack[%0d]: ack seen, want none", ab); end
      txn(0, 1'b0, ADDR_W'(2047), '0, cyc, nrd, nwr);
      checks++; if (cyc != 2 + RD_LAT) begin errors++; $display("FAIL reissue_latency: got %0d want %0d", cyc, 2 + RD_LAT); end
      checks++; if (r0_rdata !== v) begin errors++; $display("FAIL reissue_data: got %0h want %0h", r0_rdata, v); end
    end
  endtask

  task automatic test_random();
    int cyc, nrd, nwr, p, sel;
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 60; i++) begin
      p   = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      a   = (sel == 0) ? ADDR_W'(0) : (sel == 1) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom_range(0, 15));
      d   = DATA_W'($urandom);
      txn(p, we, a, d, cyc, nrd, nwr);
      checks++; if (cyc != (we ? 2 : 2 + RD_LAT)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d we=%b", i, cyc, we); end
      checks++; if (nrd != int'(!we) || nwr != int'(we)) begin errors++; $display("FAIL rnd_strobes[%0d]: rd=%0d wr=%0d we=%b", i, nrd, nwr, we); end
      checks++; if (st_addr !== a) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, st_addr, a); end
      if (we) begin
        checks++; if (st_wdata !== d) begin errors++; $display("FAIL rnd_wdata[%0d]: got %0h want %0h", i, st_wdata, d); end
      end
      checks++; if (r0_rdata !== exp_rd[0]) begin errors++; $display("FAIL rnd_r0_rdata[%0d]: got %0h want %0h", i, r0_rdata, exp_rd[0]); end
      checks++; if (r1_rdata !== exp_rd[1]) begin errors++; $display("FAIL rnd_r1_rdata[%0d]: got %0h want %0h", i, r1_rdata, exp_rd[1]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    exp_rd[0] = '0; exp_rd[1] = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
